// File: rtl/execute_pipe.sv
// Execute stage: single-cycle ALU, compare flags, branch target generation,
// and an iterative shift-add multiplier. A one-entry result register faces a
// valid/ready handshake on each side.
module execute_pipe #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 7,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        control_in,
  input  logic [IDX_W-1:0]  dest_index_in,
  input  logic [DATA_W-1:0] reg1_data,
  input  logic [DATA_W-1:0] reg2_data,
  input  logic [DATA_W-1:0] npc,
  input  logic [IMM_W-1:0]  immediate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        control_out,
  output logic [IDX_W-1:0]  dest_index_out,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] target,
  output logic              DEST_REG_WRITE_EN,
  output logic              ZF,
  output logic              GF,
  output logic              LF
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MUL_BUSY = 1'b1;

  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_SLL  = 5'b00111;
  localparam logic [4:0] OP_SRL  = 5'b01000;
  localparam logic [4:0] OP_CMP  = 5'b01001;
  localparam logic [4:0] OP_MUL  = 5'b01010;
  localparam logic [4:0] OP_BR   = 5'b01011;

  // Architectural / pipeline registers
  logic [0:0]        state_q,     state_d;
  logic              out_valid_q, out_valid_d;
  logic [4:0]        ctrl_q,      ctrl_d;
  logic [IDX_W-1:0]  dest_q,      dest_d;
  logic [DATA_W-1:0] result_q,    result_d;
  logic [DATA_W-1:0] target_q,    target_d;
  logic              we_q,        we_d;
  logic              zf_q,        zf_d;
  logic              gf_q,        gf_d;
  logic              lf_q,        lf_d;

  // Multiplier working registers
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [DATA_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q,    acc_d;

  // Combinational helpers
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_we;
  logic [DATA_W-1:0] acc_step;
  logic              accept;
  logic              cmp_eq, cmp_gt, cmp_lt;

  assign imm_ext  = {{(DATA_W-IMM_W){immediate[IMM_W-1]}}, immediate};
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign cmp_eq = (reg1_data == reg2_data);
  assign cmp_gt = ($signed(reg1_data) > $signed(reg2_data));
  assign cmp_lt = ($signed(reg1_data) < $signed(reg2_data));

  // Single-cycle ALU result and write-enable decode
  always_comb begin
    alu_res = '0;
    alu_we  = 1'b0;
    case (control_in)
      OP_SUB:  begin alu_res = reg1_data - reg2_data;            alu_we = 1'b1; end
      OP_ADD:  begin alu_res = reg1_data + reg2_data;            alu_we = 1'b1; end
      OP_ADDI: begin alu_res = reg1_data + imm_ext;              alu_we = 1'b1; end
      OP_AND:  begin alu_res = reg1_data & reg2_data;            alu_we = 1'b1; end
      OP_OR:   begin alu_res = reg1_data | reg2_data;            alu_we = 1'b1; end
      OP_XOR:  begin alu_res = reg1_data ^ reg2_data;            alu_we = 1'b1; end
      OP_SLL:  begin alu_res = reg1_data << reg2_data[SH_W-1:0]; alu_we = 1'b1; end
      OP_SRL:  begin alu_res = reg1_data >> reg2_data[SH_W-1:0]; alu_we = 1'b1; end
      OP_MUL:  begin alu_res = '0;                               alu_we = 1'b1; end
      OP_CMP:  begin alu_res = '0;                               alu_we = 1'b0; end
      OP_BR:   begin alu_res = '0;                               alu_we = 1'b0; end
      default: begin alu_res = '0;                               alu_we = 1'b0; end
    endcase
  end

  // Next-state: flush beats an in-flight multiply, which beats acceptance
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    dest_d      = dest_q;
    result_d    = result_q;
    target_d    = target_q;
    we_d        = we_q;
    zf_d        = zf_q;
    gf_d        = gf_q;
    lf_d        = lf_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
      cnt_d       = '0;
    end else if (state_q == MUL_BUSY) begin
      // One partial product per cycle; the last step writes straight to the
      // result register so the answer appears after exactly DATA_W edges.
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        result_d    = acc_step;
        cnt_d       = '0;
      end
    end else if (accept) begin
      ctrl_d   = control_in;
      dest_d   = dest_index_in;
      we_d     = alu_we;
      target_d = (control_in == OP_BR) ? (npc + imm_ext) : npc;
      if (control_in == OP_MUL) begin
        state_d     = MUL_BUSY;
        out_valid_d = 1'b0;
        acc_d       = '0;
        mcand_d     = reg1_data;
        mplier_d    = reg2_data;
        cnt_d       = '0;
      end else begin
        out_valid_d = 1'b1;
        result_d    = alu_res;
        if (control_in == OP_CMP) begin
          zf_d = cmp_eq;
          gf_d = cmp_gt;
          lf_d = cmp_lt;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      dest_q      <= '0;
      result_q    <= '0;
      target_q    <= '0;
      we_q        <= 1'b0;
      zf_q        <= 1'b0;
      gf_q        <= 1'b0;
      lf_q        <= 1'b0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      dest_q      <= dest_d;
      result_q    <= result_d;
      target_q    <= target_d;
      we_q        <= we_d;
      zf_q        <= zf_d;
      gf_q        <= gf_d;
      lf_q        <= lf_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign control_out       = ctrl_q;
  assign dest_index_out    = dest_q;
  assign result_out        = result_q;
  assign target            = target_q;
  assign DEST_REG_WRITE_EN = we_q;
  assign ZF                = zf_q;
  assign GF                = gf_q;
  assign LF                = lf_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Bench for execute_pipe: directed vectors, a behavioural model checked every
// cycle, and literal expectations for the key scenarios.
module tb_execute_pipe;
  localparam int DW = 16;
  localparam int IW = 7;
  localparam int XW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, out_ready;
  logic [4:0]    control_in;
  logic [XW-1:0] dest_index_in;
  logic [DW-1:0] reg1_data, reg2_data, npc;
  logic [IW-1:0] immediate;
  logic          in_ready, out_valid, DEST_REG_WRITE_EN, ZF, GF, LF;
  logic [4:0]    control_out;
  logic [XW-1:0] dest_index_out;
  logic [DW-1:0] result_out, target;

  // 32-bit instance for the wide multiply
  logic          in_valid_w;
  logic [4:0]    control_in_w;
  logic [31:0]   a_w, b_w, npc_w;
  logic          in_ready_w, out_valid_w, we_w, zf_w, gf_w, lf_w;
  logic [4:0]    control_out_w;
  logic [XW-1:0] dest_out_w;
  logic [31:0]   result_w, target_w;

  execute_pipe #(.DATA_W(DW), .IMM_W(IW), .IDX_W(XW)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .control_in(control_in), .dest_index_in(dest_index_in), .reg1_data(reg1_data),
    .reg2_data(reg2_data), .npc(npc), .immediate(immediate), .out_valid(out_valid),
    .out_ready(out_ready), .control_out(control_out), .dest_index_out(dest_index_out),
    .result_out(result_out), .target(target), .DEST_REG_WRITE_EN(DEST_REG_WRITE_EN),
    .ZF(ZF), .GF(GF), .LF(LF)
  );

  execute_pipe #(.DATA_W(32), .IMM_W(IW), .IDX_W(XW)) u_dut32 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .control_in(control_in_w), .dest_index_in(5'd9), .reg1_data(a_w),
    .reg2_data(b_w), .npc(npc_w), .immediate(7'd0), .out_valid(out_valid_w),
    .out_ready(1'b1), .control_out(control_out_w), .dest_index_out(dest_out_w),
    .result_out(result_w), .target(target_w), .DEST_REG_WRITE_EN(we_w),
    .ZF(zf_w), .GF(gf_w), .LF(lf_w)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          m_ov;
  int            m_busy;
  logic [DW-1:0] m_res, m_tgt, m_pend;
  logic [4:0]    m_ctl;
  logic [XW-1:0] m_dst;
  logic          m_we, m_chkres;
  logic [2:0]    m_flags;   // {ZF,GF,LF}
  logic          m_rdy;

  function automatic logic [DW-1:0] sext(input logic [IW-1:0] imm);
    return {{(DW-IW){imm[IW-1]}}, imm};
  endfunction

  function automatic logic [DW-1:0] model_alu(input logic [4:0] op,
      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [IW-1:0] imm);
    logic [31:0] prod;
    prod = a * b;
    case (op)
      5'd1:    return a - b;
      5'd2:    return a + b;
      5'd3:    return a + sext(imm);
      5'd4:    return a & b;
      5'd5:    return a | b;
      5'd6:    return a ^ b;
      5'd7:    return a << (b % DW);
      5'd8:    return a >> (b % DW);
      5'd10:   return prod[DW-1:0];
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    m_rdy = (m_busy == 0) && (!m_ov || out_ready);
    if (reset) begin
      m_ov = 1'b0; m_busy = 0; m_flags = 3'b000;
    end else if (flush) begin
      m_ov = 1'b0; m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_ov = 1'b1; m_res = m_pend; end
    end else if (in_valid && m_rdy) begin
      m_ctl     = control_in;
      m_dst     = dest_index_in;
      m_tgt     = (control_in == 5'd11) ? npc + sext(immediate) : npc;
      m_we      = (control_in >= 5'd1 && control_in <= 5'd8) || control_in == 5'd10;
      m_chkres  = (control_in != 5'd9);
      if (control_in == 5'd10) begin
        m_busy = DW; m_ov = 1'b0;
        m_pend = model_alu(control_in, reg1_data, reg2_data, immediate);
      end else begin
        m_ov  = 1'b1;
        m_res = model_alu(control_in, reg1_data, reg2_data, immediate);
        if (control_in == 5'd9)
          m_flags = {reg1_data == reg2_data,
                     $signed(reg1_data) > $signed(reg2_data),
                     $signed(reg1_data) < $signed(reg2_data)};
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      chk("in_ready", in_ready, (m_busy == 0) && (!m_ov || out_ready));
      chk("out_valid", out_valid, m_ov);
      chk("flags", {ZF, GF, LF}, m_flags);
      if (m_ov) begin
        chk("control_out", control_out, m_ctl);
        chk("dest_index_out", dest_index_out, m_dst);
        chk("target", target, m_tgt);
        chk("write_en", DEST_REG_WRITE_EN, m_we);
        if (m_chkres) chk("result_out", result_out, m_res);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [4:0] op, input logic [XW-1:0] d, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [DW-1:0] pc, input logic [IW-1:0] imm);
    @(negedge clk);
    in_valid = 1'b1; control_in = op; dest_index_in = d;
    reg1_data = a; reg2_data = b; npc = pc; immediate = imm;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [4:0]    op;
    logic [DW-1:0] a, b, exp;
    logic          we;
  } vec_t;

  vec_t tbl [8] = '{
    '{5'd4,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b1},
    '{5'd5,  16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b1},
    '{5'd6,  16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b1},
    '{5'd7,  16'h0001, 16'h0013, 16'h0008, 1'b1},
    '{5'd8,  16'h8000, 16'h0004, 16'h0800, 1'b1},
    '{5'd1,  16'h0003, 16'h0005, 16'hFFFE, 1'b1},
    '{5'd12, 16'h0005, 16'h0005, 16'h0000, 1'b0},
    '{5'd0,  16'h0005, 16'h0005, 16'h0000, 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, nbusy, nov;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    control_in = '0; dest_index_in = '0; reg1_data = '0; reg2_data = '0;
    npc = '0; immediate = '0;
    in_valid_w = 1'b0; control_in_w = '0; a_w = '0; b_w = '0; npc_w = '0;
    m_ov = 1'b0; m_busy = 0; m_flags = 3'b000; m_res = '0; m_tgt = '0; m_pend = '0;
    m_ctl = '0; m_dst = '0; m_we = 1'b0; m_chkres = 1'b0; m_rdy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset result", result_out, 0);
    chk("reset target", target, 0);
    chk("reset control", control_out, 0);
    chk("reset dest", dest_index_out, 0);
    chk("reset we", DEST_REG_WRITE_EN, 0);
    chk("reset flags", {ZF, GF, LF}, 3'b000);

    // SUB 10-3
    drive(5'd1, 5'd2, 16'd10, 16'd3, 16'd100, 7'd0);
    idle(); #2;
    chk("sub valid", out_valid, 1);
    chk("sub result", result_out, 16'd7);
    chk("sub dest", dest_index_out, 5'd2);
    chk("sub we", DEST_REG_WRITE_EN, 1);

    // Back-to-back ADD, ADDI +7, ADDI -1
    drive(5'd2, 5'd3, 16'd10, 16'd5, 16'd0, 7'd0);
    drive(5'd3, 5'd4, 16'd10, 16'd0, 16'd0, 7'h07);
    #2; chk("b2b add", result_out, 16'd15); chk("b2b ready1", in_ready, 1);
    drive(5'd3, 5'd5, 16'd10, 16'd0, 16'd0, 7'h7F);
    #2; chk("b2b addi", result_out, 16'd17); chk("b2b ready2", in_ready, 1);
    idle(); #2;
    chk("b2b addi neg", result_out, 16'd9);

    // Logic, shifts, undefined opcodes
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].op, 5'd6, tbl[i].a, tbl[i].b, 16'd40, 7'd0);
      idle(); #2;
      chk($sformatf("vec%0d result", i), result_out, tbl[i].exp);
      chk($sformatf("vec%0d we", i), DEST_REG_WRITE_EN, tbl[i].we);
    end

    // Compare flags
    drive(5'd9, 5'd0, 16'd5, 16'd5, 16'd0, 7'd0);
    idle(); #2; chk("cmp eq", {ZF, GF, LF}, 3'b100);
    drive(5'd9, 5'd0, 16'hFFFE, 16'd3, 16'd0, 7'd0);
    idle(); #2; chk("cmp lt", {ZF, GF, LF}, 3'b001);
    drive(5'd9, 5'd0, 16'd3, 16'hFFFE, 16'd0, 7'd0);
    drive(5'd2, 5'd1, 16'd1, 16'd1, 16'd0, 7'd0);
    #2; chk("cmp gt", {ZF, GF, LF}, 3'b010); chk("cmp we", DEST_REG_WRITE_EN, 0);
    drive(5'd11, 5'd1, 16'd0, 16'd0, 16'd20, 7'h7C);
    #2; chk("add keeps flags", {ZF, GF, LF}, 3'b010);
    idle(); #2;
    chk("br target", target, 16'd16);
    chk("br we", DEST_REG_WRITE_EN, 0);
    chk("br result", result_out, 0);

    // Backpressure: hold for 3 cycles while another op is offered
    drive(5'd1, 5'd4, 16'd10, 16'd3, 16'd8, 7'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(5'd2, 5'd7, 16'd100, 16'd100, 16'd50, 7'd0);
      #2;
      chk("hold valid", out_valid, 1);
      chk("hold result", result_out, 16'd7);
      chk("hold dest", dest_index_out, 5'd4);
      chk("hold ready", in_ready, 0);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    #2; chk("release ready", in_ready, 1);
    @(negedge clk); #2; chk("release drained", out_valid, 0);

    // MUL 300*300 at 16 bits
    drive(5'd10, 5'd8, 16'd300, 16'd300, 16'd0, 7'd0);
    idle(); #2;
    n = 0; nbusy = 0;
    while (!out_valid && n < 40) begin
      if (!in_ready) nbusy++;
      @(negedge clk); #2; n++;
    end
    chk("mul16 timeout", n < 40, 1);
    chk("mul16 busy cycles", nbusy, 16);
    chk("mul16 result", result_out, 16'd24464);
    chk("mul16 we", DEST_REG_WRITE_EN, 1);

    // MUL 300*300 at 32 bits
    @(negedge clk);
    in_valid_w = 1'b1; control_in_w = 5'd10; a_w = 32'd300; b_w = 32'd300; npc_w = 32'd4;
    @(negedge clk); in_valid_w = 1'b0; #2;
    n = 0; nbusy = 0;
    while (!out_valid_w && n < 80) begin
      if (!in_ready_w) nbusy++;
      @(negedge clk); #2; n++;
    end
    chk("mul32 timeout", n < 80, 1);
    chk("mul32 busy cycles", nbusy, 32);
    chk("mul32 result", result_w, 32'd90000);
    chk("mul32 dest", dest_out_w, 5'd9);

    // Flush at cycle 5 of a MUL, with an op offered in the same cycle
    drive(5'd10, 5'd8, 16'd300, 16'd300, 16'd0, 7'd0);
    idle();
    repeat (3) @(negedge clk);
    drive(5'd2, 5'd3, 16'd1, 16'd2, 16'd0, 7'd0);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    #2;
    chk("flush valid", out_valid, 0);
    chk("flush ready", in_ready, 1);
    chk("flush flags", {ZF, GF, LF}, 3'b010);
    nov = 0;
    repeat (20) begin @(negedge clk); #2; if (out_valid) nov++; end
    chk("flush no pulse", nov, 0);
    drive(5'd1, 5'd2, 16'd10, 16'd3, 16'd0, 7'd0);
    idle(); #2;
    chk("post-flush sub", result_out, 16'd7);

    // Reset at cycle 5 of a MUL
    drive(5'd10, 5'd8, 16'd300, 16'd300, 16'd0, 7'd0);
    idle();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #2;
    chk("rst valid", out_valid, 0);
    chk("rst ready", in_ready, 1);
    chk("rst control", control_out, 0);
    chk("rst flags", {ZF, GF, LF}, 3'b000);
    nov = 0;
    repeat (20) begin @(negedge clk); #2; if (out_valid) nov++; end
    chk("rst no pulse", nov, 0);
    drive(5'd1, 5'd2, 16'd10, 16'd3, 16'd0, 7'd0);
    idle(); #2;
    chk("post-reset sub", result_out, 16'd7);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
